// File: rtl/cplx_prod_combiner_if.sv
// rtl/cplx_prod_combiner_if.sv - partial-product in / complex-result out handshake bundle
interface cplx_prod_combiner_if #(
  parameter int PROD_W = 8,
  parameter int OUT_W  = PROD_W + 2
);
  logic                     prod_valid;
  logic                     prod_ready;
  logic [PROD_W-1:0]        prod_data;
  logic [1:0]               prod_tag;
  logic                     cplx_valid;
  logic                     cplx_ready;
  logic signed [OUT_W-1:0]  cplx_re;
  logic signed [OUT_W-1:0]  cplx_im;

  // Combiner side: consumes product beats, produces complex results
  modport slave (
    input  prod_valid, prod_data, prod_tag, cplx_ready,
    output prod_ready, cplx_valid, cplx_re, cplx_im
  );

  // Surrounding logic side: offers product beats, takes complex results
  modport master (
    output prod_valid, prod_data, prod_tag, cplx_ready,
    input  prod_ready, cplx_valid, cplx_re, cplx_im
  );
endinterface

// File: rtl/cplx_prod_combiner.sv
// rtl/cplx_prod_combiner.sv - folds ac,bd,ad,bc partial products into re/im (optional CPLX_CONJ_EN adds conj port)
module cplx_prod_combiner #(
  parameter int PROD_W = 8,
  parameter int OUT_W  = PROD_W + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cplx_prod_combiner_if.slave  bus,
  output logic                 tag_err
`ifdef CPLX_CONJ_EN
  , input logic                conj
`endif
);

  typedef enum logic {COLLECT = 1'b0, OUTPUT = 1'b1} state_t;

  state_t                  state;
  logic [1:0]              cnt;
  logic signed [OUT_W-1:0] re_acc;
  logic signed [OUT_W-1:0] im_acc;
  logic                    prod_ready_q;
  logic                    cplx_valid_q;
  logic                    tag_err_q;
  logic                    conj_sel;
  logic                    accept;
  logic                    tag_ok;
  logic signed [OUT_W-1:0] p_ext;

  // Products are unsigned; widen with zeros so the signed sums cannot wrap
  assign p_ext  = $signed({{(OUT_W-PROD_W){1'b0}}, bus.prod_data});
  assign accept = bus.prod_valid && prod_ready_q;
  assign tag_ok = (bus.prod_tag == cnt);

`ifdef CPLX_CONJ_EN
  logic conj_q;

  // Conjugate mode is latched with the tag-0 beat and held for the whole result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conj_q <= 1'b0;
    end else if (accept && tag_ok && (cnt == 2'd0)) begin
      conj_q <= conj;
    end
  end

  // Tag-1 and tag-2 steps must already see the mode captured at tag 0
  assign conj_sel = conj_q;
`else
  assign conj_sel = 1'b0;
`endif

  // Collect four tagged beats in order, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      cnt          <= 2'd0;
      re_acc       <= '0;
      im_acc       <= '0;
      prod_ready_q <= 1'b1;
      cplx_valid_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (tag_ok) begin
              case (cnt)
                2'd0: re_acc <= p_ext;
                2'd1: re_acc <= conj_sel ? (re_acc + p_ext) : (re_acc - p_ext);
                2'd2: im_acc <= conj_sel ? -p_ext : p_ext;
                default: begin
                  im_acc       <= im_acc + p_ext;
                  state        <= OUTPUT;
                  prod_ready_q <= 1'b0;
                  cplx_valid_q <= 1'b1;
                end
              endcase
              // Wraps to 0 after tag 3, ready for the next set
              cnt <= cnt + 2'd1;
            end else begin
              // Out-of-order beat: drop it and restart; tag 0 reloads both sums
              tag_err_q <= 1'b1;
              cnt       <= 2'd0;
            end
          end
        end
        OUTPUT: begin
          if (bus.cplx_ready) begin
            state        <= COLLECT;
            cnt          <= 2'd0;
            prod_ready_q <= 1'b1;
            cplx_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= COLLECT;
          cnt          <= 2'd0;
          prod_ready_q <= 1'b1;
          cplx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.cplx_valid = cplx_valid_q;
  assign bus.cplx_re    = re_acc;
  assign bus.cplx_im    = im_acc;
  assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_cplx_prod_combiner.sv
// tb/tb_cplx_prod_combiner.sv - directed checks of the complex product combiner
module tb_cplx_prod_combiner;

  localparam int PROD_W = 8;
  localparam int OUT_W  = 10;

  logic clk;
  logic rst_n;
  logic tag_err;
  int   n_checks;
  int   n_errors;
`ifdef CPLX_CONJ_EN
  logic conj;
`endif

  cplx_prod_combiner_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

  cplx_prod_combiner #(.PROD_W(PROD_W), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tag_err (tag_err)
`ifdef CPLX_CONJ_EN
    , .conj  (conj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Hold one beat over one rising edge; caller drops prod_valid when done
  task automatic beat(input int tag, input int data);
    bus.prod_valid = 1'b1;
    bus.prod_tag   = tag[1:0];
    bus.prod_data  = data[PROD_W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic four_beats(input int p0, input int p1, input int p2, input int p3);
    beat(0, p0);
    beat(1, p1);
    beat(2, p2);
    check("valid_before_last", int'(bus.cplx_valid), 0);
    beat(3, p3);
    bus.prod_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input int re, input int im);
    check({name, "_valid"}, int'(bus.cplx_valid), 1);
    check({name, "_pready"}, int'(bus.prod_ready), 0);
    check({name, "_re"}, int'($signed(bus.cplx_re)), re);
    check({name, "_im"}, int'($signed(bus.cplx_im)), im);
  endtask

  task automatic handshake(input string name);
    bus.cplx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cplx_ready = 1'b0;
    check({name, "_hs_valid"}, int'(bus.cplx_valid), 0);
    check({name, "_hs_pready"}, int'(bus.prod_ready), 1);
  endtask

  initial begin
    logic [OUT_W-1:0] raw;
    int re_hold;
    int im_hold;
    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus.prod_valid = 1'b0;
    bus.prod_tag   = 2'd0;
    bus.prod_data  = '0;
    bus.cplx_ready = 1'b0;
`ifdef CPLX_CONJ_EN
    conj = 1'b0;
`endif
    #12;
    check("rst_pready", int'(bus.prod_ready), 1);
    check("rst_valid", int'(bus.cplx_valid), 0);
    check("rst_re", int'($signed(bus.cplx_re)), 0);
    check("rst_im", int'($signed(bus.cplx_im)), 0);
    check("rst_tag_err", int'(tag_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ac=15 bd=8 ad=12 bc=10 -> 7 + 22i
    four_beats(15, 8, 12, 10);
    expect_result("basic", 7, 22);
    check("basic_tag_err", int'(tag_err), 0);
    handshake("basic");

    // Extreme values: re goes negative
    four_beats(0, 225, 225, 225);
    expect_result("neg", -225, 450);
    raw = bus.cplx_re;
    check("neg_re_raw", int'(raw), 'h31F);
    handshake("neg");

    // Full-scale corners
    four_beats(255, 0, 255, 255);
    expect_result("max", 255, 510);
    handshake("max");

    // Backpressure: six stalled cycles
    four_beats(15, 8, 12, 10);
    re_hold = int'($signed(bus.cplx_re));
    im_hold = int'($signed(bus.cplx_im));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", int'(bus.cplx_valid), 1);
      check("stall_pready", int'(bus.prod_ready), 0);
      check("stall_re", int'($signed(bus.cplx_re)), 7);
      check("stall_im", int'($signed(bus.cplx_im)), 22);
    end
    check("stall_hold_re", re_hold, 7);
    check("stall_hold_im", im_hold, 22);
    handshake("stall");

    // Out-of-order tag then a clean set
    beat(0, 5);
    beat(2, 7);
    bus.prod_valid = 1'b0;
    check("oo_tag_err", int'(tag_err), 1);
    check("oo_valid", int'(bus.cplx_valid), 0);
    check("oo_pready", int'(bus.prod_ready), 1);
    four_beats(4, 1, 2, 3);
    expect_result("oo_recover", 3, 5);
    check("oo_tag_err_sticky", int'(tag_err), 1);
    handshake("oo_recover");

    // Reset in the middle of a set
    beat(0, 1);
    beat(1, 2);
    bus.prod_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_pready", int'(bus.prod_ready), 1);
    check("mid_rst_valid", int'(bus.cplx_valid), 0);
    check("mid_rst_re", int'($signed(bus.cplx_re)), 0);
    check("mid_rst_im", int'($signed(bus.cplx_im)), 0);
    check("mid_rst_tag_err", int'(tag_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    four_beats(9, 3, 4, 6);
    expect_result("post_rst", 6, 10);
    check("post_rst_tag_err", int'(tag_err), 0);

    // Reset while a result is pending
    rst_n = 1'b0;
    #2;
    check("out_rst_valid", int'(bus.cplx_valid), 0);
    check("out_rst_pready", int'(bus.prod_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("out_rst_no_result", int'(bus.cplx_valid), 0);

`ifdef CPLX_CONJ_EN
    // Conjugate mode: (ac+bd) + (bc-ad)i
    conj = 1'b1;
    beat(0, 15);
    conj = 1'b0;
    beat(1, 8);
    beat(2, 12);
    beat(3, 10);
    bus.prod_valid = 1'b0;
    expect_result("conj", 23, -2);
    handshake("conj");
    four_beats(15, 8, 12, 10);
    expect_result("conj_off", 7, 22);
    handshake("conj_off");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cplx_prod_combiner.md
CPLX_PROD_COMBINER -- requirements
Module: cplx_prod_combiner

Interface
REQ-001 SHALL have parameter PROD_W, default 8, width of one unsigned real partial product from the 4x4 multiplier stage.
REQ-002 SHALL have parameter OUT_W, default PROD_W+2, width of each signed complex output component.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port prod_valid  input  1  partial product beat offered.
REQ-006 SHALL have port prod_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port prod_data  input  PROD_W  unsigned partial product.
REQ-008 SHALL have port prod_tag  input  2  product identity: 0=ac, 1=bd, 2=ad, 3=bc.
REQ-009 SHALL have port cplx_valid  output  1  complex result available.
REQ-010 SHALL have port cplx_ready  input  1  downstream accepts result.
REQ-011 SHALL have port cplx_re  output  OUT_W  signed real part, two's complement.
REQ-012 SHALL have port cplx_im  output  OUT_W  signed imaginary part, two's complement.
REQ-013 SHALL have port tag_err  output  1  sticky: out-of-order tag seen since reset.

Function
REQ-014 SHALL implement two states: COLLECT (beat counter 0..3) and OUTPUT.
REQ-015 SHALL drive prod_ready=1 in COLLECT and 0 in OUTPUT, from registered state only (no combinational path from cplx_ready).
REQ-016 SHALL accept a beat when prod_valid && prod_ready; beat is consumed in that cycle.
REQ-017 SHALL require accepted tags in order 0,1,2,3; counter equals expected tag.
REQ-018 On accepted beat with tag==counter: tag 0 loads re_acc=+P, tag 1 re_acc-=P, tag 2 loads im_acc=+P, tag 3 im_acc+=P; all zero-extended to OUT_W before arithmetic, no saturation.
REQ-019 On accepted beat with tag!=counter: discard beat, set tag_err, counter to 0, accumulators unchanged (overwritten by next tag 0).
REQ-020 After tag 3 accepted, SHALL enter OUTPUT next cycle with cplx_valid=1; latency last beat accept -> cplx_valid is exactly 1 cycle.
REQ-021 cplx_re/cplx_im SHALL hold stable while cplx_valid && !cplx_ready.
REQ-022 On cplx_valid && cplx_ready: cplx_valid=0 and COLLECT (counter 0) next cycle; prod_ready=1 that same next cycle.
REQ-023 Minimum throughput: one complex result per 5 cycles (4 beats + 1 output).
REQ-024 cplx_re/cplx_im SHALL reflect accumulator registers directly; values outside OUTPUT are don't-care for checking but deterministic.
REQ-025 Range: re in [-(2^PROD_W-1), 2^PROD_W-1], im in [0, 2*(2^PROD_W-1)]; OUT_W SHALL never overflow.

Reset
REQ-026 rst_n low SHALL asynchronously force COLLECT, counter 0, prod_ready=1, cplx_valid=0, cplx_re=0, cplx_im=0, tag_err=0.
REQ-027 Reset mid-collection or during OUTPUT SHALL discard partial/pending result; no result emitted for it.
REQ-028 Release of rst_n SHALL be synchronous to clk; first beat acceptable on first rising edge after release.

Configuration
REQ-029 Macro CPLX_CONJ_EN: when defined, SHALL add port conj input 1, sampled with tag-0 beat and held for that result.
REQ-030 With CPLX_CONJ_EN and conj=1: tag 1 re_acc+=P, tag 2 im_acc=-P, tag 3 im_acc+=P (result (ac+bd)+(bc-ad)i); conj=0 behaves per REQ-018.
REQ-031 Without CPLX_CONJ_EN: no conj port, behaviour exactly REQ-018.

Verification
REQ-032 Beats (0,15),(1,8),(2,12),(3,10) back-to-back -> cplx_valid 1 cycle after 4th beat, re=7, im=22.
REQ-033 Beats (0,0),(1,225),(2,225),(3,225) -> re=-225 (0x31F in 10 bits), im=450.
REQ-034 cplx_ready held 0 for 6 cycles after valid -> prod_ready=0, outputs stable, then single handshake and prod_ready=1 next cycle.
REQ-035 Beats (0,5),(2,7) -> tag_err=1, counter 0; following correct 4-beat set (0,4),(1,1),(2,2),(3,3) -> re=3, im=5.
REQ-036 rst_n asserted after 2 beats -> all outputs reset values immediately; next full set gives correct result with no stale data.
REQ-037 With CPLX_CONJ_EN, conj=1, beats (0,15),(1,8),(2,12),(3,10) -> re=23, im=-2.
